// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants and region decode for the memory/IO byte bus.
//   IO_REGION : value of the two region bits that select memory-mapped IO
//   IO_SEL_W  : width of the IO register select
//   BYTE_W    : bus data width
//   is_io()   : region decode of a master address
package mem_bus_pkg;

  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int         IO_SEL_W  = 3;
  localparam int         BYTE_W    = 8;

  // IO is selected by address bits [ram_aw : ram_aw-1]; everything else is RAM.
  function automatic logic is_io(input logic [63:0] addr, input int unsigned ram_aw);
    logic [63:0] sh;
    sh = addr >> (ram_aw - 1);
    return sh[1:0] == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter: round-robin grant over a request vector.
//   clk, rst : clock, synchronous active-high reset
//   req      : eligible requests, one bit per master
//   gnt      : one-hot grant (combinational), zero while in reset
//   gnt_idx  : binary index of the granted master
//   gnt_any  : a grant is issued this cycle
// The search starts just above the last winner, so a continuously requesting
// master waits at most NUM_MASTERS-1 cycles.
module rr_arbiter #(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_any
);

  logic [IDX_W-1:0] rr_last;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst) begin
      for (int off = 1; off <= NUM_MASTERS; off++) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (!gnt_any && req[i] && (i == (int'(rr_last) + off) % NUM_MASTERS)) begin
            gnt_any = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= IDX_W'(NUM_MASTERS - 1);
    end else if (gnt_any) begin
      rr_last <= gnt_idx;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port and the memory-mapped IO space among
// NUM_MASTERS byte-bus masters.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   dbg_active          : only master DBG_IDX may be granted while high
//   m_req/m_wr/m_a/m_dout : packed per-master request, direction, address, write data
//   m_gnt               : one-hot grant, same cycle as the transaction issues
//   m_rvalid, m_din     : read return one cycle after a granted read
//   ram_en/ram_r_nw/ram_a/ram_d/ram_q : RAM port
//   io_en/io_wr/io_sel/io_d/io_q/io_full : IO port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DBG_IDX        = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          dbg_active,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
  input  logic [NUM_MASTERS*BYTE_W-1:0] m_dout,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [BYTE_W-1:0]             m_din,
  output logic                          ram_en,
  output logic                          ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_a,
  output logic [BYTE_W-1:0]             ram_d,
  input  logic [BYTE_W-1:0]             ram_q,
  output logic                          io_en,
  output logic                          io_wr,
  output logic [IO_SEL_W-1:0]           io_sel,
  output logic [BYTE_W-1:0]             io_d,
  input  logic [BYTE_W-1:0]             io_q,
  input  logic                          io_full
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]    region_io;
  logic [NUM_MASTERS-1:0]    elig;
  logic [NUM_MASTERS-1:0]    gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      gnt_any;

  logic [RAM_ADDR_WIDTH-1:0] sel_a;
  logic [BYTE_W-1:0]         sel_d;
  logic                      sel_wr;
  logic                      sel_io;

  logic                      pend_vld_p1;
  logic [IDX_W-1:0]          pend_owner_p1;
  logic                      pend_io_p1;

  // An IO write facing a full buffer just drops out of arbitration so it
  // cannot starve the other masters; IO reads stay eligible.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_elig
    assign region_io[g] = is_io(64'(m_a[g*ADDR_WIDTH +: ADDR_WIDTH]), RAM_ADDR_WIDTH);
    assign elig[g] = m_req[g]
                   && !(m_wr[g] && region_io[g] && io_full)
                   && (!dbg_active || (g == DBG_IDX));
  end

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr (
    .clk     (clk_in),
    .rst     (rst_in),
    .req     (elig),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign m_gnt = gnt;

  // One-hot AND-OR select; all fields fall to zero with no grant.
  always_comb begin
    sel_a  = '0;
    sel_d  = '0;
    sel_wr = 1'b0;
    sel_io = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_a  = m_a[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
        sel_d  = m_dout[i*BYTE_W +: BYTE_W];
        sel_wr = m_wr[i];
        sel_io = region_io[i];
      end
    end
  end

  // ---- stage p0: issue to RAM or IO ----
  assign ram_en   = gnt_any && !sel_io;
  assign ram_r_nw = !(ram_en && sel_wr);
  assign ram_a    = ram_en ? sel_a : '0;
  assign ram_d    = (ram_en && sel_wr) ? sel_d : '0;
  assign io_en    = gnt_any && sel_io;
  assign io_wr    = io_en && sel_wr;
  assign io_sel   = io_en ? sel_a[IO_SEL_W-1:0] : '0;
  assign io_d     = io_wr ? sel_d : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_vld_p1 <= 1'b0;
    end else begin
      pend_vld_p1 <= gnt_any && !sel_wr;
    end
  end

  always_ff @(posedge clk_in) begin
    pend_owner_p1 <= gnt_idx;
    pend_io_p1    <= sel_io;
  end

  // ---- stage p1: read return ----
  // Gating with rst_in drops a read that was granted just before reset.
  always_comb begin
    m_rvalid = '0;
    m_din    = '0;
    if (pend_vld_p1 && !rst_in) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (pend_owner_p1 == IDX_W'(i)) m_rvalid[i] = 1'b1;
      end
      m_din = pend_io_p1 ? io_q : ram_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, dbg_active, io_full;
  logic [1:0]  m_req, m_wr, m_gnt, m_rvalid;
  logic [63:0] m_a;
  logic [15:0] m_dout;
  logic [7:0]  m_din, ram_d, ram_q, io_d, io_q;
  logic        ram_en, ram_r_nw, io_en, io_wr;
  logic [16:0] ram_a;
  logic [2:0]  io_sel;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .dbg_active (dbg_active),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_a        (m_a),
    .m_dout     (m_dout),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_din      (m_din),
    .ram_en     (ram_en),
    .ram_r_nw   (ram_r_nw),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_q      (ram_q),
    .io_en      (io_en),
    .io_wr      (io_wr),
    .io_sel     (io_sel),
    .io_d       (io_d),
    .io_q       (io_q),
    .io_full    (io_full)
  );

  typedef struct {
    logic        rst, dbg, full;
    logic [1:0]  req, wr;
    logic [31:0] a0, a1;
    logic [7:0]  d0, d1, rdat;
    logic [1:0]  gnt;
  } vec_t;

  typedef struct {
    logic [1:0] owner;
    logic       io;
    logic [7:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rst, dbg, full, input logic [1:0] req, wr,
                              input logic [31:0] a0, a1, input logic [7:0] d0, d1, rdat,
                              input logic [1:0] gnt);
    vec_t v;
    v.rst = rst; v.dbg = dbg; v.full = full; v.req = req; v.wr = wr;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.rdat = rdat; v.gnt = gnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic        have, any, g_wr, g_io;
    logic [31:0] g_a;
    logic [7:0]  g_d;
    sb_t         e;
    @(negedge clk);
    have = (sb.size() > 0);
    if (have) begin
      e = sb.pop_front();
      ram_q = e.io ? ~e.data : e.data;
      io_q  = e.io ? e.data : ~e.data;
    end else begin
      ram_q = 8'($urandom);
      io_q  = 8'($urandom);
    end
    rst_in     = v.rst;
    dbg_active = v.dbg;
    io_full    = v.full;
    m_req      = v.req;
    m_wr       = v.wr;
    m_a        = {v.a1, v.a0};
    m_dout     = {v.d1, v.d0};
    #1;
    any  = |v.gnt;
    g_a  = v.gnt[1] ? v.a1 : (v.gnt[0] ? v.a0 : 32'h0);
    g_d  = v.gnt[1] ? v.d1 : v.d0;
    g_wr = v.gnt[1] ? v.wr[1] : v.wr[0];
    g_io = (g_a[17:16] == 2'b11);
    chk("m_gnt",    32'(m_gnt),    32'(v.gnt));
    chk("ram_en",   32'(ram_en),   32'(any && !g_io));
    chk("io_en",    32'(io_en),    32'(any && g_io));
    chk("io_wr",    32'(io_wr),    32'(any && g_io && g_wr));
    chk("ram_r_nw", 32'(ram_r_nw), 32'(!(any && !g_io && g_wr)));
    if (any && !g_io) chk("ram_a", 32'(ram_a), 32'(g_a[16:0]));
    if (any && g_io)  chk("io_sel", 32'(io_sel), 32'(g_a[2:0]));
    if (any && g_wr)  chk("wdata", 32'(g_io ? io_d : ram_d), 32'(g_d));
    if (have && !v.rst) begin
      chk("m_rvalid", 32'(m_rvalid), 32'(e.owner));
      chk("m_din",    32'(m_din),    32'(e.data));
    end else begin
      chk("m_rvalid", 32'(m_rvalid), 32'h0);
      chk("m_din",    32'(m_din),    32'h0);
    end
    if (!v.rst && any && !g_wr) sb.push_back('{owner: v.gnt, io: g_io, data: v.rdat});
  endtask

  initial begin
    rst_in = 1'b1; dbg_active = 1'b0; io_full = 1'b0;
    m_req = '0; m_wr = '0; m_a = '0; m_dout = '0; ram_q = '0; io_q = '0;

    // Single RAM read by master 0, then return.
    vecs.push_back(mk(1,0,0,2'b11,2'b00,32'h10,   32'h20,   0,0,0,    2'b00));
    vecs.push_back(mk(0,0,0,2'b01,2'b00,32'h10,   32'h0,    0,0,8'hA5,2'b01));
    vecs.push_back(mk(0,0,0,2'b00,2'b00,32'h0,    32'h0,    0,0,0,    2'b00));
    // Fresh reset, then continuous contention alternates starting at master 0.
    vecs.push_back(mk(1,0,0,2'b00,2'b00,32'h0,    32'h0,    0,0,0,    2'b00));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0,0,0,2'b11,2'b00,32'h100,32'h200,0,0,8'(8'h10+k),
                        (k % 2 == 1) ? 2'b10 : 2'b01));
    // Master 1 IO write stalled by io_full; master 0 keeps running.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,1,2'b11,2'b10,32'h20, 32'h30004,0,8'h5C,8'(8'h20+k),2'b01));
    vecs.push_back(mk(0,0,0,2'b11,2'b10,32'h20,   32'h30004,0,8'h5C,0,   2'b10));
    // IO read followed by RAM read: returns must not swap.
    vecs.push_back(mk(0,0,0,2'b10,2'b00,32'h0,    32'h30000,0,0,8'h41,2'b10));
    vecs.push_back(mk(0,0,0,2'b01,2'b00,32'h30,   32'h0,    0,0,8'h7E,2'b01));
    vecs.push_back(mk(0,0,0,2'b00,2'b00,32'h0,    32'h0,    0,0,0,    2'b00));
    // Debug mode: only master 0.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,1,0,2'b11,2'b00,32'h40, 32'h50,   0,0,8'(8'h60+k),2'b01));
    vecs.push_back(mk(0,1,0,2'b10,2'b00,32'h0,    32'h50,   0,0,0,    2'b00));
    vecs.push_back(mk(0,0,0,2'b11,2'b00,32'h40,   32'h30001,0,0,8'h6A,2'b10));
    // dbg rises while master 1's IO read is in flight: it still returns.
    vecs.push_back(mk(0,1,0,2'b11,2'b00,32'h40,   32'h50,   0,0,8'h6B,2'b01));
    // Reset right after a granted read: no rvalid; then master 0 wins first.
    vecs.push_back(mk(1,0,0,2'b11,2'b00,32'h40,   32'h50,   0,0,0,    2'b00));
    vecs.push_back(mk(0,0,0,2'b11,2'b00,32'h40,   32'h50,   0,0,8'h6C,2'b01));
    // IO read allowed while io_full.
    vecs.push_back(mk(0,0,1,2'b10,2'b00,32'h0,    32'h30007,0,0,8'h77,2'b10));
    // RAM write: no read return afterwards.
    vecs.push_back(mk(0,0,0,2'b01,2'b01,32'h50,   32'h0,    8'h99,0,0,2'b01));
    vecs.push_back(mk(0,0,0,2'b00,2'b00,32'h0,    32'h0,    0,0,0,    2'b00));

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Hand sequence: IO write blocked by io_full while it is the only request,
    // then released; the write issues the cycle io_full falls.
    apply(mk(0,0,1,2'b10,2'b10,32'h0,32'h30002,0,8'hC3,0,2'b00));
    apply(mk(0,0,1,2'b10,2'b10,32'h0,32'h30002,0,8'hC3,0,2'b00));
    apply(mk(0,0,0,2'b10,2'b10,32'h0,32'h30002,0,8'hC3,0,2'b10));
    apply(mk(0,0,0,2'b00,2'b00,32'h0,32'h0,    0,0,    0,2'b00));

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised successor to the top-level memory/IO byte-bus mux. It lets NUM_MASTERS requesters (CPU ports, debug host, future DMA) share the single RAM and the memory-mapped IO space. Arbitration is round-robin with a debug-override mode. Write requests to IO stall while the IO buffer is full. Read data returns one cycle later, steered by a registered region/owner record. It sits between the masters and the ram/hci blocks in riscv_top.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..8)
ADDR_WIDTH, 32, master address width
RAM_ADDR_WIDTH, 17, RAM address width; bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11 select IO
DBG_IDX, 0, index of the master allowed to run while dbg_active is high

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
dbg_active  in  1  debug break; only master DBG_IDX may be granted
m_req  in  NUM_MASTERS  per-master request, held until granted
m_wr  in  NUM_MASTERS  1 = write, 0 = read
m_a  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dout  in  NUM_MASTERS*8  packed write data
m_gnt  out  NUM_MASTERS  one-hot grant, combinational, same cycle as issue
m_rvalid  out  NUM_MASTERS  one-hot read-data-valid, one cycle after a granted read
m_din  out  8  read data, broadcast to all masters, qualified by m_rvalid
ram_en  out  1  RAM enable
ram_r_nw  out  1  1 = read, 0 = write
ram_a  out  RAM_ADDR_WIDTH  RAM address
ram_d  out  8  RAM write data
ram_q  in  8  RAM read data, valid one cycle after enable
io_en  out  1  IO enable
io_wr  out  1  IO write
io_sel  out  3  IO register select (address bits [2:0])
io_d  out  8  IO write data
io_q  in  8  IO read data, valid one cycle after io_en
io_full  in  1  IO output buffer full

Behaviour:
- Region decode per master: IO when a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11, otherwise RAM.
- Eligible(i) = m_req[i] && !(m_wr[i] && IO(i) && io_full) && (!dbg_active || i==DBG_IDX).
- Round-robin:
  - Register rr_last, reset value NUM_MASTERS-1.
  - The grant goes to the first eligible master searching from rr_last+1 upward, modulo NUM_MASTERS.
  - rr_last updates to the granted index on a grant; it holds when there is no grant.
- At most one grant per cycle. The granted transaction drives exactly one of ram_en / io_en; the other stays 0.
- With no grant: ram_en=0, io_en=0, ram_r_nw=1, io_wr=0. Address and data outputs are don't-care; drive them 0.
- Read return:
  - Register pend_valid, pend_owner, pend_io on every granted read.
  - The next cycle: m_rvalid[pend_owner]=1, and m_din = pend_io ? io_q : ram_q.
  - Writes produce no rvalid.
- Back-to-back: a new grant may issue in the same cycle an earlier read returns. Throughput is 1 transaction/cycle.
- A blocked IO write (io_full) does not block other masters; it simply loses eligibility. An IO read during io_full is allowed.
- dbg_active rising mid-stream: a read already granted still returns its rvalid the next cycle. Non-debug masters see m_gnt=0 until dbg_active falls.
- Reset (rst_in=1):
  - m_gnt=0, ram_en=0, io_en=0, io_wr=0, ram_r_nw=1, m_rvalid=0, m_din=0.
  - pend_valid cleared, rr_last=NUM_MASTERS-1.
  - A read granted in the cycle before reset returns no rvalid.
- NUM_MASTERS=1: the arbiter degenerates to pass-through with the same latency and stall rules.

Decomposition:
- Package mem_bus_pkg: IO_REGION=2'b11, IO_SEL_W=3, BYTE_W=8, and a region-decode function is_io(addr).
- One sub-module, rr_arbiter: NUM_MASTERS request vector in, one-hot grant and binary index out, rr_last register inside, synchronous reset. All other logic stays in mem_bus_arbiter.

Test Plan:
- Master 0 reads RAM 0x00010, master 1 idle, ram_q=0xA5 -> cycle 0 m_gnt=01, ram_en=1, ram_r_nw=1; cycle 1 m_rvalid=01, m_din=0xA5.
- Both masters request reads continuously for 6 cycles after reset -> grants alternate 01,10,01,10,01,10; each rvalid goes to the correct master one cycle later.
- Master 1 writes IO 0x30004 with io_full=1 for 3 cycles, master 0 reads RAM -> master 0 granted every cycle, master 1 never. io_full falls -> master 1 granted that cycle with io_en=1, io_wr=1, io_sel=3'b100.
- Master 1 reads IO 0x30000 (io_q=0x41), master 0 reads RAM next cycle (ram_q=0x7E) -> returns 0x41 with rvalid=10, then 0x7E with rvalid=01; no data swap.
- dbg_active=1, both masters request -> only DBG_IDX (master 0) is granted; master 1 is granted the first cycle after dbg_active falls.
- Read granted, rst_in asserted the following cycle -> m_rvalid stays 0; after reset the first contention grants master 0.
